// File: rtl/conv_kernel_ctrl.sv
// Raster position tracker and double-buffered kernel configuration for conv_kernel.
// Optional frame counter enabled by defining CONV_CTRL_FRAME_CNT_EN.
module conv_kernel_ctrl #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int SIZE         = 11,
    parameter int KERNEL_WIDTH = 7
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                valid_i,
    input  logic                                cfg_we,
    input  logic [7:0]                          cfg_addr,
    input  logic [KERNEL_WIDTH-1:0]             cfg_data,
    input  logic                                cfg_commit,
    output logic                                cfg_busy,
    output logic [12:0]                         row,
    output logic [12:0]                         col,
    output logic                                sof,
    output logic                                eof,
    output logic [SIZE*SIZE*KERNEL_WIDTH-1:0]   kernel_o,
    output logic [KERNEL_WIDTH-1:0]             norm_o,
    output logic                                kernel_swap,
    output logic [15:0]                         frame_count
);

    localparam int NCOEF = SIZE * SIZE;
    localparam int NENT  = NCOEF + 1;
    localparam int SETW  = NENT * KERNEL_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;

    // Box blur: every coefficient 1, normalizer equal to the coefficient count.
    function automatic logic [SETW-1:0] resetSet();
        logic [SETW-1:0] v;
        v = '0;
        for (int k = 0; k < NCOEF; k++) begin
            v[k*KERNEL_WIDTH +: KERNEL_WIDTH] = KERNEL_WIDTH'(1);
        end
        v[NCOEF*KERNEL_WIDTH +: KERNEL_WIDTH] = KERNEL_WIDTH'(NCOEF);
        return v;
    endfunction

    localparam logic [SETW-1:0] RESET_SET = resetSet();

    logic [12:0]     rowCnt_q, rowCnt_d;
    logic [12:0]     colCnt_q, colCnt_d;
    logic [1:0]      state_q, state_d;
    logic [SETW-1:0] shadow_q, shadow_d;
    logic [SETW-1:0] active_q, active_d;
    logic            swapPulse_q;
    logic            wrAccept;
    logic            doSwap;
    logic            atLineEnd;
    logic            atFrameEnd;

    assign atLineEnd  = (colCnt_q == 13'(WIDTH - 1));
    assign atFrameEnd = atLineEnd && (rowCnt_q == 13'(HEIGHT - 1));

    assign row  = rowCnt_q;
    assign col  = colCnt_q;
    assign sof  = valid_i && (rowCnt_q == 13'd0) && (colCnt_q == 13'd0);
    assign eof  = valid_i && atFrameEnd;

    assign cfg_busy    = (state_q == PENDING);
    assign wrAccept    = cfg_we && !cfg_busy && (cfg_addr <= 8'(NCOEF));
    assign kernel_o    = active_q[NCOEF*KERNEL_WIDTH-1:0];
    assign norm_o      = active_q[NCOEF*KERNEL_WIDTH +: KERNEL_WIDTH];
    assign kernel_swap = swapPulse_q;

    always_comb begin
        rowCnt_d = rowCnt_q;
        colCnt_d = colCnt_q;
        if (valid_i) begin
            if (atFrameEnd) begin
                rowCnt_d = 13'd0;
                colCnt_d = 13'd0;
            end else if (atLineEnd) begin
                rowCnt_d = rowCnt_q + 13'd1;
                colCnt_d = 13'd0;
            end else begin
                colCnt_d = colCnt_q + 13'd1;
            end
        end
    end

    // A commit arriving with eof swaps immediately; otherwise it waits for the frame end.
    always_comb begin
        state_d = state_q;
        doSwap  = 1'b0;
        case (state_q)
            IDLE: begin
                doSwap = cfg_commit;
                if (valid_i) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cfg_commit && eof) begin
                    doSwap = 1'b1;
                end else if (cfg_commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (eof) begin
                    doSwap  = 1'b1;
                    state_d = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Swap copies the post-write shadow so a same-cycle write is not lost.
    always_comb begin
        shadow_d = shadow_q;
        if (wrAccept) begin
            shadow_d[int'(cfg_addr)*KERNEL_WIDTH +: KERNEL_WIDTH] = cfg_data;
        end
        active_d = doSwap ? shadow_d : active_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rowCnt_q    <= '0;
            colCnt_q    <= '0;
            state_q     <= IDLE;
            shadow_q    <= RESET_SET;
            active_q    <= RESET_SET;
            swapPulse_q <= 1'b0;
        end else begin
            rowCnt_q    <= rowCnt_d;
            colCnt_q    <= colCnt_d;
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            swapPulse_q <= doSwap;
        end
    end

`ifdef CONV_CTRL_FRAME_CNT_EN
    logic [15:0] frameCnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameCnt_q <= '0;
        end else if (eof) begin
            frameCnt_q <= frameCnt_q + 16'd1;
        end
    end

    assign frame_count = frameCnt_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Directed self-checking bench for conv_kernel_ctrl on a 4x3 frame.
// Honours CONV_CTRL_FRAME_CNT_EN for the frame_count expectations.
module tb_conv_kernel_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int S  = 11;
    localparam int KW = 7;
    localparam int NPIX = W * H;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  valid_i = 1'b0;
    logic                  cfg_we = 1'b0;
    logic [7:0]            cfg_addr = 8'd0;
    logic [KW-1:0]         cfg_data = '0;
    logic                  cfg_commit = 1'b0;
    logic                  cfg_busy;
    logic [12:0]           row;
    logic [12:0]           col;
    logic                  sof;
    logic                  eof;
    logic [S*S*KW-1:0]     kernel_o;
    logic [KW-1:0]         norm_o;
    logic                  kernel_swap;
    logic [15:0]           frame_count;

    int testsRun = 0;
    int testsFailed = 0;

    conv_kernel_ctrl #(
        .WIDTH(W), .HEIGHT(H), .SIZE(S), .KERNEL_WIDTH(KW)
    ) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
        .row(row), .col(col), .sof(sof), .eof(eof),
        .kernel_o(kernel_o), .norm_o(norm_o),
        .kernel_swap(kernel_swap), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic commit,
                                 input logic [7:0] addr, input logic [KW-1:0] data);
        valid_i    = v;
        cfg_we     = we;
        cfg_commit = commit;
        cfg_addr   = addr;
        cfg_data   = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] entry(input int k);
        return kernel_o[k*KW +: KW];
    endfunction

    function automatic int expFrames(input int n);
`ifdef CONV_CTRL_FRAME_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // One valid pixel at raster index idx, checking position and frame flags before the edge.
    task automatic pixelCheck(input int idx);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, '0);
        checkOutput("row", 32'(row), 32'(idx / W));
        checkOutput("col", 32'(col), 32'(idx % W));
        checkOutput("sof", 32'(sof), 32'(idx == 0));
        checkOutput("eof", 32'(eof), 32'(idx == NPIX - 1));
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(cfg_busy), 32'd0);
        checkOutput("rst_row", 32'(row), 32'd0);
        checkOutput("rst_col", 32'(col), 32'd0);
        checkOutput("rst_swap", 32'(kernel_swap), 32'd0);
        checkOutput("rst_norm", 32'(norm_o), 32'd121);
        checkOutput("rst_k0", 32'(entry(0)), 32'd1);
        checkOutput("rst_fc", 32'(frame_count), 32'd0);
        reset = 1'b0;
        tick();

        // Write and commit while idle: immediate swap, never busy.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd0, 7'h7D);
        checkOutput("idle_busy0", 32'(cfg_busy), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
        checkOutput("idle_k0", 32'(entry(0)), 32'h7D);
        checkOutput("idle_swap", 32'(kernel_swap), 32'd1);
        checkOutput("idle_busy1", 32'(cfg_busy), 32'd0);
        checkOutput("idle_norm", 32'(norm_o), 32'd121);
        tick();
        checkOutput("idle_swap_off", 32'(kernel_swap), 32'd0);

        for (int i = 0; i < NPIX; i++) pixelCheck(i);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
        checkOutput("wrap_row", 32'(row), 32'd0);
        checkOutput("wrap_col", 32'(col), 32'd0);
        checkOutput("fc1", 32'(frame_count), 32'(expFrames(1)));

        for (int i = 0; i < NPIX; i++) begin
            pixelCheck(i);
            applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
            for (int g = 0; g < 2; g++) begin
                checkOutput("gap_row", 32'(row), 32'(((i + 1) % NPIX) / W));
                checkOutput("gap_col", 32'(col), 32'((i + 1) % W));
                checkOutput("gap_eof", 32'(eof), 32'd0);
                tick();
            end
        end
        checkOutput("fc2", 32'(frame_count), 32'(expFrames(2)));

        // Mid-frame commit waits for eof; writes while busy are dropped.
        for (int i = 0; i < 5; i++) pixelCheck(i);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd121, 7'd9);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd1, 7'd5);
        checkOutput("pend_busy", 32'(cfg_busy), 32'd1);
        checkOutput("pend_swap", 32'(kernel_swap), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
        for (int i = 5; i < NPIX; i++) begin
            checkOutput("pend_busy_hold", 32'(cfg_busy), 32'd1);
            checkOutput("pend_norm_old", 32'(norm_o), 32'd121);
            pixelCheck(i);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
        checkOutput("pend_norm_new", 32'(norm_o), 32'd9);
        checkOutput("pend_swap_pulse", 32'(kernel_swap), 32'd1);
        checkOutput("pend_busy_clr", 32'(cfg_busy), 32'd0);
        checkOutput("pend_k1", 32'(entry(1)), 32'd1);
        checkOutput("pend_k0", 32'(entry(0)), 32'h7D);
        tick();
        checkOutput("pend_swap_off", 32'(kernel_swap), 32'd0);
        checkOutput("fc3", 32'(frame_count), 32'(expFrames(3)));

        // Commit coinciding with eof, with a write-through in the same cycle.
        for (int i = 0; i < NPIX - 1; i++) pixelCheck(i);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd2, 7'd4);
        checkOutput("eofc_eof", 32'(eof), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
        checkOutput("eofc_busy", 32'(cfg_busy), 32'd0);
        checkOutput("eofc_swap", 32'(kernel_swap), 32'd1);
        checkOutput("eofc_k2", 32'(entry(2)), 32'd4);
        checkOutput("eofc_norm", 32'(norm_o), 32'd9);
        tick();
        checkOutput("eofc_busy2", 32'(cfg_busy), 32'd0);
        checkOutput("eofc_swap_off", 32'(kernel_swap), 32'd0);
        checkOutput("fc4", 32'(frame_count), 32'(expFrames(4)));

        // Asynchronous reset while a commit is pending.
        for (int i = 0; i < 3; i++) pixelCheck(i);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
        checkOutput("prst_busy", 32'(cfg_busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(cfg_busy), 32'd0);
        checkOutput("arst_row", 32'(row), 32'd0);
        checkOutput("arst_col", 32'(col), 32'd0);
        checkOutput("arst_norm", 32'(norm_o), 32'd121);
        checkOutput("arst_swap", 32'(kernel_swap), 32'd0);
        checkOutput("arst_fc", 32'(frame_count), 32'd0);
        for (int k = 0; k < S * S; k++) checkOutput("arst_k", 32'(entry(k)), 32'd1);
        #1;
        reset = 1'b0;
        tick();
        checkOutput("post_busy", 32'(cfg_busy), 32'd0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) pixelCheck(i);
        end
        checkOutput("post_fc3", 32'(frame_count), 32'(expFrames(3)));
        checkOutput("post_norm", 32'(norm_o), 32'd121);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/conv_kernel_ctrl.md
# conv_kernel_ctrl

Sequencing and configuration controller for the streaming convolution datapath (`conv_kernel`). It tracks raster position of the incoming pixel stream and flags start and end of each frame. It holds a shadow and an active copy of the kernel coefficients and normalizing factor, and swaps them only on a frame boundary so no frame is filtered with a mixed kernel. It sits between the pixel source (`valid`) and `conv_kernel`, and drives `kernel`/`normalizing_factor` plus `row`/`col` for `RGB_Process`.

## Interface
- `WIDTH`, 640, active pixels per line
- `HEIGHT`, 480, lines per frame
- `SIZE`, 11, kernel dimension (SIZE×SIZE coefficients)
- `KERNEL_WIDTH`, 7, signed coefficient and normalizer width
- `clk  in  1`  pixel clock; single clock domain
- `reset  in  1`  asynchronous, active-high reset
- `valid_i  in  1`  pixel present on the stream this cycle
- `cfg_we  in  1`  write one shadow entry
- `cfg_addr  in  8`  0..SIZE*SIZE-1 = coefficient (row-major, addr = i*SIZE+j); SIZE*SIZE = normalizer
- `cfg_data  in  KERNEL_WIDTH`  write data
- `cfg_commit  in  1`  request shadow→active swap
- `cfg_busy  out  1`  commit pending; writes rejected
- `row  out  13`, `col  out  13`  coordinates of the pixel carried by `valid_i` this cycle
- `sof  out  1`, `eof  out  1`  combinational: `valid_i` at (0,0) / at (HEIGHT-1,WIDTH-1)
- `kernel_o  out  SIZE*SIZE*KERNEL_WIDTH`  active coefficients, entry k at bits [k*KERNEL_WIDTH +: KERNEL_WIDTH]
- `norm_o  out  KERNEL_WIDTH`  active normalizer
- `kernel_swap  out  1`  one-cycle pulse the cycle after active set changes
- `frame_count  out  16`  completed frames (see Configuration)

## Operation
- Reset values: row=col=0, state IDLE, cfg_busy=0, kernel_swap=0, frame_count=0; shadow and active coefficients all = 1, normalizer = SIZE*SIZE (box blur, 121 at defaults).
- Position counters advance only on `valid_i`: col+1; at col=WIDTH-1 → col=0, row+1; at row=HEIGHT-1,col=WIDTH-1 → row=0,col=0. No advance without `valid_i`; gaps are legal anywhere.
- Writes: accepted when `cfg_we` and not `cfg_busy` and cfg_addr ≤ SIZE*SIZE; otherwise ignored silently. Writes touch shadow only.
- FSM:
  - IDLE (no pixel since reset): `cfg_commit` → swap at this edge, stay IDLE. First `valid_i` → ACTIVE (commit in same cycle takes IDLE path).
  - ACTIVE: `cfg_commit` → PENDING (cfg_busy=1 next cycle). If `cfg_commit` coincides with `eof`, swap at this edge, stay ACTIVE.
  - PENDING: on `eof` edge → swap, ACTIVE, cfg_busy=0. `cfg_commit` ignored.
- Swap: active ← shadow on the clock edge; an accepted write in the same cycle is included in the copied value (write-through mux). First pixel of next frame therefore always sees new kernel.
- Never returns to IDLE except by reset.

## Timing
- row/col/sof/eof valid in the same cycle as `valid_i`; counters update on that edge.
- Swap latency: 0 cycles after eof edge; `kernel_o`/`norm_o` change on that edge; `kernel_swap` high exactly the following cycle.
- cfg_busy rises the cycle after commit accepted in ACTIVE, falls the cycle after the eof edge.
- Reset asserted mid-frame: all state returns to reset values immediately (async); pending commit discarded; shadow contents lost.

## Configuration
- `CONV_CTRL_FRAME_CNT_EN`: defined → `frame_count` increments (wraps at 65535→0) on every eof edge. Undefined → counter logic omitted, `frame_count` tied to 0.

## Test plan
- Reset then WIDTH=4,HEIGHT=3, `valid_i` continuous 12 cycles → col 0..3 repeat, row 0,1,2, sof on cycle 0, eof on cycle 11, back to (0,0) cycle 12.
- `valid_i` with 2-cycle gaps → row/col hold during gaps, eof still on 12th valid pixel.
- IDLE: write addr 0 = -3 and commit same cycle → next cycle kernel_o entry 0 = -3, kernel_swap pulse, cfg_busy never 1.
- ACTIVE mid-frame: write norm=9, commit → cfg_busy=1; further write to addr 1 ignored; norm_o stays 121 until eof edge, then 9; kernel_swap high one cycle after; entry 1 still 1.
- Commit in same cycle as eof → swap on that edge, cfg_busy stays 0.
- Reset pulse while PENDING → cfg_busy=0, row=col=0, kernel_o all 1, norm_o=121; with macro, frame_count=0 and counts 3 after three frames.
